ladybird_uart_rx_fifo: RTL and testbench

Parametrised UART receiver with a runtime baud divisor and runtime frame format (parity none/even/odd, 1 or 2 stop bits). It flags framing and parity errors, detects line break, and buffers received words in an on-chip FIFO drained by a valid/ready stream. It is the next-generation replacement for the fixed 8N1 single-register receiver in the ladybird SoC and sits between the board RX pin and the core's debug/console path.

---
 rtl/ladybird_uart_rx_fifo.sv | 232 +++++++++++++++++++++++
 tb/tb_ladybird_uart_rx_fifo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ladybird_uart_rx_fifo.sv
// UART receiver with runtime baud divisor and frame format, break detection,
// and a receive FIFO drained through a valid/ready stream.
module ladybird_uart_rx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          rx,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          two_stop,
    output logic                          valid,
    output logic [DATA_BITS-1:0]          data,
    output logic                          frame_err,
    output logic                          parity_err,
    input  logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic                          brk
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam int unsigned ENT_W = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_WAIT_HIGH
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_rx_meta;
    logic                   r_rxs;
    logic [DIV_W-1:0]       r_cnt;
    logic [DIV_W-1:0]       r_div;
    logic                   r_par_en;
    logic                   r_par_odd;
    logic                   r_two_stop;
    logic [BIT_W-1:0]       r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_err;
    logic                   r_par_sample;
    logic                   r_stop1;
    logic [ENT_W-1:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [LVL_W-1:0]       r_level;
    logic                   r_overrun;
    logic                   r_brk;

    logic                   w_tick;
    logic                   w_start;
    logic                   w_finish;
    logic                   w_stop_bad;
    logic                   w_stops_low;
    logic                   w_brk;
    logic                   w_push_req;
    logic                   w_push;
    logic                   w_pop;
    logic [ENT_W-1:0]       w_head;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    assign w_tick  = (r_state != S_IDLE) && (r_cnt == '0);
    assign w_start = (r_state == S_IDLE) && !r_rxs;

    // Bit timer: half a bit preloaded in IDLE so the first tick hits mid start bit.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= baud_div >> 1;
        end else if (w_tick) begin
            r_cnt <= r_div - DIV_W'(1);
        end else begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_div        <= '0;
            r_par_en     <= 1'b0;
            r_par_odd    <= 1'b0;
            r_two_stop   <= 1'b0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_par_err    <= 1'b0;
            r_par_sample <= 1'b0;
            r_stop1      <= 1'b1;
        end else begin
            if (w_start) begin
                r_div        <= baud_div;
                r_par_en     <= parity_en;
                r_par_odd    <= parity_odd;
                r_two_stop   <= two_stop;
                r_bit        <= '0;
                r_par_err    <= 1'b0;
                r_par_sample <= 1'b0;
                r_stop1      <= 1'b1;
            end
            if (w_tick) begin
                case (r_state)
                    S_DATA: begin
                        r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
                        r_bit   <= r_bit + BIT_W'(1);
                    end
                    S_PARITY: begin
                        r_par_sample <= r_rxs;
                        r_par_err    <= (r_rxs != (^r_shift ^ r_par_odd));
                    end
                    S_STOP1: r_stop1 <= r_rxs;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_finish    = 1'b0;
        w_stop_bad  = 1'b0;
        w_stops_low = 1'b0;
        w_brk       = 1'b0;
        case (r_state)
            S_IDLE:      if (!r_rxs) w_next = S_START;
            S_START:     if (w_tick) w_next = r_rxs ? S_IDLE : S_DATA;
            S_DATA:      if (w_tick && (r_bit == BIT_W'(DATA_BITS - 1)))
                             w_next = r_par_en ? S_PARITY : S_STOP1;
            S_PARITY:    if (w_tick) w_next = S_STOP1;
            S_STOP1: begin
                if (w_tick) begin
                    if (r_two_stop) begin
                        w_next = S_STOP2;
                    end else begin
                        w_finish    = 1'b1;
                        w_stop_bad  = !r_rxs;
                        w_stops_low = !r_rxs;
                    end
                end
            end
            S_STOP2: begin
                if (w_tick) begin
                    w_finish    = 1'b1;
                    w_stop_bad  = !r_stop1 || !r_rxs;
                    w_stops_low = !r_stop1 && !r_rxs;
                end
            end
            S_WAIT_HIGH: if (r_rxs) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        // Break: an all-zero frame including every stop sample.
        w_brk = w_finish && w_stops_low && (r_shift == '0) && (!r_par_en || !r_par_sample);
        if (w_finish) begin
            w_next = (w_brk || w_stop_bad) ? S_WAIT_HIGH : S_IDLE;
        end
    end

    assign w_pop      = (r_level != '0) && ready;
    assign w_push_req = w_finish && !w_brk;
    assign w_push     = w_push_req && ((r_level != LVL_W'(FIFO_DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_stop_bad, r_par_err, r_shift};
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
            r_brk     <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LVL_W'(1);
            end
            // A dropped word outranks a simultaneous clear.
            if (w_push_req && !w_push) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
            r_brk <= w_brk;
        end
    end

    // Head fields are gated so an empty FIFO presents zeros.
    assign w_head     = r_mem[r_rd_ptr];
    assign valid      = (r_level != '0);
    assign data       = valid ? w_head[DATA_BITS-1:0] : '0;
    assign parity_err = valid & w_head[DATA_BITS];
    assign frame_err  = valid & w_head[DATA_BITS+1];
    assign level      = r_level;
    assign overrun    = r_overrun;
    assign brk        = r_brk;

endmodule

// File: tb/tb_ladybird_uart_rx_fifo.sv
// Directed bench for ladybird_uart_rx_fifo: frame formats, errors, break,
// glitch rejection, FIFO full/overrun behaviour and reset.
module tb_ladybird_uart_rx_fifo;

    localparam int BAUD = 16;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] baud_div = 16'(BAUD);
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        two_stop = 1'b0;
    logic        valid;
    logic [7:0]  data;
    logic        frame_err;
    logic        parity_err;
    logic        ready = 1'b0;
    logic [4:0]  level;
    logic        overrun;
    logic        overrun_clr = 1'b0;
    logic        brk;

    int tests_run = 0;
    int tests_failed = 0;
    int brk_cnt = 0;

    ladybird_uart_rx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_W(16)) dut (
        .clk(clk), .nrst(nrst), .rx(rx), .baud_div(baud_div),
        .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
        .valid(valid), .data(data), .frame_err(frame_err), .parity_err(parity_err),
        .ready(ready), .level(level), .overrun(overrun), .overrun_clr(overrun_clr),
        .brk(brk)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (brk === 1'b1) brk_cnt++;

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_on, input logic par_bit,
                              input logic stop1, input logic stop2_on, input logic stop2);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par_on) send_bit(par_bit);
        send_bit(stop1);
        if (stop2_on) send_bit(stop2);
    endtask

    task automatic pop_one();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic do_reset();
        nrst = 1'b0; rx = 1'b1; ready = 1'b0; overrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid got %b want 0", valid); end
        tests_run++; if (data !== 8'h00) begin tests_failed++; $display("FAIL rst_data got %h want 00", data); end
        tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL rst_frame_err got %b want 0", frame_err); end
        tests_run++; if (parity_err !== 1'b0) begin tests_failed++; $display("FAIL rst_parity_err got %b want 0", parity_err); end
        tests_run++; if (level !== 5'd0) begin tests_failed++; $display("FAIL rst_level got %0d want 0", level); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL rst_overrun got %b want 0", overrun); end
        tests_run++; if (brk !== 1'b0) begin tests_failed++; $display("FAIL rst_brk got %b want 0", brk); end
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_8n1_back_to_back();
        int t = 0, t1 = 0, t2 = 0;
        fork
            begin
                send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            begin
                while (level !== 5'd1 && t < 400) begin @(negedge clk); t++; end
                t1 = t;
                while (level !== 5'd2 && t < 400) begin @(negedge clk); t++; end
                t2 = t;
            end
        join
        tests_run++; if (t1 < 148 || t1 > 160) begin tests_failed++; $display("FAIL 8n1_push1_time got %0d want 148..160", t1); end
        tests_run++; if (t2 < 308 || t2 > 320) begin tests_failed++; $display("FAIL 8n1_push2_time got %0d want 308..320", t2); end
        tests_run++; if (level !== 5'd2) begin tests_failed++; $display("FAIL 8n1_level got %0d want 2", level); end
        tests_run++; if (valid !== 1'b1) begin tests_failed++; $display("FAIL 8n1_valid got %b want 1", valid); end
        tests_run++; if (data !== 8'hA5) begin tests_failed++; $display("FAIL 8n1_data0 got %h want a5", data); end
        tests_run++; if ({frame_err, parity_err} !== 2'b00) begin tests_failed++; $display("FAIL 8n1_err0 got %b want 00", {frame_err, parity_err}); end
        pop_one();
        tests_run++; if (data !== 8'h3C) begin tests_failed++; $display("FAIL 8n1_data1 got %h want 3c", data); end
        tests_run++; if ({frame_err, parity_err} !== 2'b00) begin tests_failed++; $display("FAIL 8n1_err1 got %b want 00", {frame_err, parity_err}); end
        tests_run++; if (level !== 5'd1) begin tests_failed++; $display("FAIL 8n1_level_pop got %0d want 1", level); end
        pop_one();
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL 8n1_empty got %b want 0", valid); end
    endtask

    task automatic test_parity();
        parity_en = 1'b1; parity_odd = 1'b0;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        parity_odd = 1'b1;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tests_run++; if (level !== 5'd2) begin tests_failed++; $display("FAIL par_level got %0d want 2", level); end
        tests_run++; if (data !== 8'h07) begin tests_failed++; $display("FAIL par_even_data got %h want 07", data); end
        tests_run++; if (parity_err !== 1'b0) begin tests_failed++; $display("FAIL par_even_err got %b want 0", parity_err); end
        pop_one();
        tests_run++; if (data !== 8'h07) begin tests_failed++; $display("FAIL par_odd_data got %h want 07", data); end
        tests_run++; if (parity_err !== 1'b1) begin tests_failed++; $display("FAIL par_odd_err got %b want 1", parity_err); end
        tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL par_odd_frame got %b want 0", frame_err); end
        pop_one();
        parity_en = 1'b0; parity_odd = 1'b0;
    endtask

    task automatic test_stop2_frame_err();
        int b0 = brk_cnt;
        two_stop = 1'b1;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        tests_run++; if (level !== 5'd1) begin tests_failed++; $display("FAIL stop2_level got %0d want 1", level); end
        tests_run++; if (data !== 8'h55) begin tests_failed++; $display("FAIL stop2_data got %h want 55", data); end
        tests_run++; if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL stop2_frame_err got %b want 1", frame_err); end
        tests_run++; if (parity_err !== 1'b0) begin tests_failed++; $display("FAIL stop2_parity_err got %b want 0", parity_err); end
        tests_run++; if (brk_cnt !== b0) begin tests_failed++; $display("FAIL stop2_brk got %0d want %0d", brk_cnt, b0); end
        pop_one();
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tests_run++; if (data !== 8'hC3) begin tests_failed++; $display("FAIL stop2_next_data got %h want c3", data); end
        tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL stop2_next_frame got %b want 0", frame_err); end
        pop_one();
        two_stop = 1'b0;
    endtask

    task automatic test_break();
        int b0 = brk_cnt;
        rx = 1'b0;
        repeat (20 * BAUD) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        tests_run++; if (brk_cnt - b0 !== 1) begin tests_failed++; $display("FAIL brk_pulses got %0d want 1", brk_cnt - b0); end
        tests_run++; if (level !== 5'd0) begin tests_failed++; $display("FAIL brk_level got %0d want 0", level); end
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++; if (level !== 5'd1) begin tests_failed++; $display("FAIL brk_next_level got %0d want 1", level); end
        tests_run++; if (data !== 8'h81) begin tests_failed++; $display("FAIL brk_next_data got %h want 81", data); end
        tests_run++; if ({frame_err, parity_err} !== 2'b00) begin tests_failed++; $display("FAIL brk_next_err got %b want 00", {frame_err, parity_err}); end
        pop_one();
    endtask

    task automatic test_glitch();
        int b0 = brk_cnt;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        tests_run++; if (level !== 5'd0) begin tests_failed++; $display("FAIL glitch_level got %0d want 0", level); end
        tests_run++; if (brk_cnt !== b0) begin tests_failed++; $display("FAIL glitch_brk got %0d want %0d", brk_cnt, b0); end
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++; if (data !== 8'h5A) begin tests_failed++; $display("FAIL glitch_next_data got %h want 5a", data); end
        pop_one();
    endtask

    task automatic test_fifo_full();
        logic [7:0] exp;
        do_reset();
        for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++; if (level !== 5'd16) begin tests_failed++; $display("FAIL full_level got %0d want 16", level); end
        tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL full_overrun got %b want 1", overrun); end
        tests_run++; if (data !== 8'h01) begin tests_failed++; $display("FAIL full_head got %h want 01", data); end
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear got %b want 0", overrun); end
        fork
            send_frame(8'hEE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            begin
                repeat (155) @(posedge clk);
                @(negedge clk); overrun_clr = 1'b1;
                @(negedge clk); overrun_clr = 1'b0;
            end
        join
        tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_set_wins got %b want 1", overrun); end
        tests_run++; if (level !== 5'd16) begin tests_failed++; $display("FAIL ovr_level got %0d want 16", level); end
        fork
            send_frame(8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            begin
                repeat (155) @(posedge clk);
                @(negedge clk); ready = 1'b1;
                @(negedge clk); ready = 1'b0;
            end
        join
        tests_run++; if (level !== 5'd16) begin tests_failed++; $display("FAIL pushpop_level got %0d want 16", level); end
        tests_run++; if (data !== 8'h02) begin tests_failed++; $display("FAIL pushpop_head got %h want 02", data); end
        ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp = (k < 15) ? 8'(k + 2) : 8'h99;
            tests_run++; if (data !== exp) begin tests_failed++; $display("FAIL drain_%0d got %h want %h", k, data, exp); end
            @(negedge clk);
        end
        ready = 1'b0;
        tests_run++; if (level !== 5'd0) begin tests_failed++; $display("FAIL drain_level got %0d want 0", level); end
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL drain_valid got %b want 0", valid); end
    endtask

    task automatic test_reset_mid_frame();
        int b0;
        send_frame(8'h42, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++; if (level !== 5'd1) begin tests_failed++; $display("FAIL mid_pre_level got %0d want 1", level); end
        rx = 1'b0;
        repeat (5 * BAUD) @(negedge clk);
        nrst = 1'b0; rx = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL mid_valid got %b want 0", valid); end
        tests_run++; if (level !== 5'd0) begin tests_failed++; $display("FAIL mid_level got %0d want 0", level); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL mid_overrun got %b want 0", overrun); end
        tests_run++; if (data !== 8'h00) begin tests_failed++; $display("FAIL mid_data got %h want 00", data); end
        nrst = 1'b1;
        b0 = brk_cnt;
        repeat (12 * BAUD) @(negedge clk);
        tests_run++; if (level !== 5'd0) begin tests_failed++; $display("FAIL mid_after_level got %0d want 0", level); end
        tests_run++; if (brk_cnt !== b0) begin tests_failed++; $display("FAIL mid_after_brk got %0d want %0d", brk_cnt, b0); end
    endtask

    initial begin
        test_reset();
        test_8n1_back_to_back();
        test_parity();
        test_stop2_frame_err();
        test_break();
        test_glitch();
        test_fifo_full();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
